// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline-stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_PC_W   = 32;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-stage register with optional two-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
//
//   state    | meaning
//   ST_EMPTY | nothing held, out_valid=0
//   ST_ONE   | main register M holds the presented instruction
//   ST_TWO   | M presented, skid register S holds the next one, in_ready=0
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  input  logic              flush,
  input  logic              stat_clr,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              in_fire;
  logic              out_fire;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic [PC_W-1:0]   m_pc;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_ctrl = m_ctrl;
  assign out_data = m_data;
  assign out_pc   = m_pc;

  generate
    if (SKID != 0) begin : g_skid
      occ_state_e        state;
      logic              in_ready_r;
      logic [CTRL_W-1:0] s_ctrl;
      logic [DATA_W-1:0] s_data;
      logic [PC_W-1:0]   s_pc;

      assign in_ready  = in_ready_r;
      assign out_valid = (state != ST_EMPTY);
      assign occupancy = state;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state      <= ST_EMPTY;
          in_ready_r <= 1'b1;
          m_ctrl     <= '0;
          m_data     <= '0;
          m_pc       <= '0;
          s_ctrl     <= '0;
          s_data     <= '0;
          s_pc       <= '0;
        end else if (flush) begin
          // Kill everything held; payload fields are left as they were.
          state      <= ST_EMPTY;
          in_ready_r <= 1'b1;
          m_ctrl     <= '0;
          s_ctrl     <= '0;
        end else begin
          case (state)
            ST_EMPTY: begin
              if (in_fire) begin
                state  <= ST_ONE;
                m_ctrl <= in_ctrl;
                m_data <= in_data;
                m_pc   <= in_pc;
              end
              in_ready_r <= 1'b1;
            end
            ST_ONE: begin
              if (in_fire && out_fire) begin
                m_ctrl <= in_ctrl;
                m_data <= in_data;
                m_pc   <= in_pc;
                in_ready_r <= 1'b1;
              end else if (in_fire) begin
                state      <= ST_TWO;
                in_ready_r <= 1'b0;
                s_ctrl     <= in_ctrl;
                s_data     <= in_data;
                s_pc       <= in_pc;
              end else if (out_fire) begin
                state      <= ST_EMPTY;
                in_ready_r <= 1'b1;
                m_ctrl     <= '0;
              end
            end
            ST_TWO: begin
              if (out_fire) begin
                state      <= ST_ONE;
                in_ready_r <= 1'b1;
                m_ctrl     <= s_ctrl;
                m_data     <= s_data;
                m_pc       <= s_pc;
                s_ctrl     <= '0;
              end
            end
            default: begin
              state      <= ST_EMPTY;
              in_ready_r <= 1'b1;
              m_ctrl     <= '0;
              s_ctrl     <= '0;
            end
          endcase
        end
      end
    end else begin : g_single
      logic valid_r;

      // Accept when empty or when the held entry leaves this same cycle.
      assign in_ready  = ~valid_r | out_ready;
      assign out_valid = valid_r;
      assign occupancy = {1'b0, valid_r};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_r <= 1'b0;
          m_ctrl  <= '0;
          m_data  <= '0;
          m_pc    <= '0;
        end else if (flush) begin
          valid_r <= 1'b0;
          m_ctrl  <= '0;
        end else if (in_fire) begin
          valid_r <= 1'b1;
          m_ctrl  <= in_ctrl;
          m_data  <= in_data;
          m_pc    <= in_pc;
        end else if (out_fire) begin
          valid_r <= 1'b0;
          m_ctrl  <= '0;
        end
      end
    end
  endgenerate

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .clr   (stat_clr),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=4) and a single-entry
// instance, each tracked by an in-order scoreboard of accepted payloads.
module tb_pipe_stage_reg;

  logic clk;
  logic rst_n;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_flush, s_stat_clr;
  logic [7:0]  s_in_ctrl, s_out_ctrl;
  logic [31:0] s_in_data, s_out_data, s_in_pc, s_out_pc;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_stall_cnt;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_flush, n_stat_clr;
  logic [7:0]  n_in_ctrl, n_out_ctrl;
  logic [31:0] n_in_data, n_out_data, n_in_pc, n_out_pc;
  logic [1:0]  n_occupancy;
  logic [15:0] n_stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [71:0] sq[$];
  logic [71:0] nq[$];
  logic [71:0] exp_s, exp_n;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .PC_W(32), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_ctrl(s_in_ctrl), .in_data(s_in_data), .in_pc(s_in_pc),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_ctrl(s_out_ctrl), .out_data(s_out_data), .out_pc(s_out_pc),
    .flush(s_flush), .stat_clr(s_stat_clr),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .PC_W(32), .SKID(0), .CNT_W(16)) u_single (
    .clk(clk), .rst_n(rst_n),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_ctrl(n_in_ctrl), .in_data(n_in_data), .in_pc(n_in_pc),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_ctrl(n_out_ctrl), .out_data(n_out_data), .out_pc(n_out_pc),
    .flush(n_flush), .stat_clr(n_stat_clr),
    .occupancy(n_occupancy), .stall_cnt(n_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ctrl_of(input logic [31:0] d);
    return 8'hC0 | {2'b00, d[5:0]};
  endfunction

  function automatic logic [31:0] pc_of(input logic [31:0] d);
    return 32'h0000_1000 + (d << 2);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_s(input logic v, input logic [31:0] d);
    s_in_valid = v; s_in_data = d; s_in_ctrl = ctrl_of(d); s_in_pc = pc_of(d);
  endtask

  task automatic drive_n(input logic v, input logic [31:0] d);
    n_in_valid = v; n_in_data = d; n_in_ctrl = ctrl_of(d); n_in_pc = pc_of(d);
  endtask

  // Scoreboard: accepted payloads are pushed at the cycle they fire and
  // popped in order when the stage hands them downstream.
  always @(negedge clk) begin
    if (!rst_n) begin
      sq.delete();
      nq.delete();
    end else begin
      if (s_out_valid && s_out_ready && !s_flush) begin
        total++;
        if (sq.size() == 0) begin
          bad++;
          $display("FAIL sb_skid: output data=%h ctrl=%h with nothing pending", s_out_data, s_out_ctrl);
        end else begin
          exp_s = sq.pop_front();
          if ({s_out_ctrl, s_out_data, s_out_pc} !== exp_s) begin
            bad++;
            $display("FAIL sb_skid: got ctrl/data/pc=%h/%h/%h want %h/%h/%h",
                     s_out_ctrl, s_out_data, s_out_pc, exp_s[71:64], exp_s[63:32], exp_s[31:0]);
          end
        end
      end
      if (s_flush) sq.delete();
      else if (s_in_valid && s_in_ready) sq.push_back({s_in_ctrl, s_in_data, s_in_pc});

      if (n_out_valid && n_out_ready && !n_flush) begin
        total++;
        if (nq.size() == 0) begin
          bad++;
          $display("FAIL sb_single: output data=%h ctrl=%h with nothing pending", n_out_data, n_out_ctrl);
        end else begin
          exp_n = nq.pop_front();
          if ({n_out_ctrl, n_out_data, n_out_pc} !== exp_n) begin
            bad++;
            $display("FAIL sb_single: got ctrl/data/pc=%h/%h/%h want %h/%h/%h",
                     n_out_ctrl, n_out_data, n_out_pc, exp_n[71:64], exp_n[63:32], exp_n[31:0]);
          end
        end
      end
      if (n_flush) nq.delete();
      else if (n_in_valid && n_in_ready) nq.push_back({n_in_ctrl, n_in_data, n_in_pc});
    end
  end

  task automatic test_reset;
    total++;
    if ({s_out_valid, s_out_ctrl, s_out_data, s_out_pc, s_occupancy, s_stall_cnt} !== 78'd0) begin
      bad++;
      $display("FAIL reset_skid_outputs: valid=%b ctrl=%h data=%h pc=%h occ=%0d stall=%0d want all zero",
               s_out_valid, s_out_ctrl, s_out_data, s_out_pc, s_occupancy, s_stall_cnt);
    end
    total++;
    if (s_in_ready !== 1'b1) begin bad++; $display("FAIL reset_skid_in_ready: got %b want 1", s_in_ready); end
    total++;
    if ({n_out_valid, n_out_ctrl, n_out_data, n_out_pc, n_occupancy, n_stall_cnt} !== 90'd0) begin
      bad++;
      $display("FAIL reset_single_outputs: valid=%b ctrl=%h data=%h occ=%0d stall=%0d want all zero",
               n_out_valid, n_out_ctrl, n_out_data, n_occupancy, n_stall_cnt);
    end
    total++;
    if (n_in_ready !== 1'b1) begin bad++; $display("FAIL reset_single_in_ready: got %b want 1", n_in_ready); end
  endtask

  task automatic test_stream;
    s_out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive_s(1'b1, i);
      tick();
      total++;
      if (s_out_valid !== 1'b1 || s_out_data !== 32'(i) || s_occupancy !== 2'd1 || s_stall_cnt !== 4'd0) begin
        bad++;
        $display("FAIL stream_%0d: valid=%b data=%h occ=%0d stall=%0d want 1/%h/1/0",
                 i, s_out_valid, s_out_data, s_occupancy, s_stall_cnt, i);
      end
    end
    drive_s(1'b0, 32'h0);
    tick();
    total++;
    if (s_out_valid !== 1'b0 || s_out_ctrl !== 8'h00 || s_occupancy !== 2'd0 || s_out_data !== 32'h3) begin
      bad++;
      $display("FAIL stream_empty: valid=%b ctrl=%h occ=%0d data=%h want 0/00/0/3",
               s_out_valid, s_out_ctrl, s_occupancy, s_out_data);
    end
  endtask

  task automatic test_backpressure;
    s_out_ready = 1'b0;
    s_stat_clr  = 1'b1;
    drive_s(1'b1, 32'h11);
    tick();
    s_stat_clr = 1'b0;
    drive_s(1'b1, 32'h22);
    tick();
    total++;
    if (s_occupancy !== 2'd2 || s_in_ready !== 1'b0 || s_out_data !== 32'h11) begin
      bad++;
      $display("FAIL bp_full: occ=%0d in_ready=%b data=%h want 2/0/11", s_occupancy, s_in_ready, s_out_data);
    end
    drive_s(1'b1, 32'h99);
    repeat (4) tick();
    total++;
    if (s_stall_cnt !== 4'd5 || s_out_data !== 32'h11 || s_out_ctrl !== ctrl_of(32'h11) || s_occupancy !== 2'd2) begin
      bad++;
      $display("FAIL bp_hold: stall=%0d data=%h ctrl=%h occ=%0d want 5/11/%h/2",
               s_stall_cnt, s_out_data, s_out_ctrl, s_occupancy, ctrl_of(32'h11));
    end
    drive_s(1'b0, 32'h0);
    s_out_ready = 1'b1;
    tick();
    total++;
    if (s_out_valid !== 1'b1 || s_out_data !== 32'h22 || s_occupancy !== 2'd1 || s_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_second: valid=%b data=%h occ=%0d in_ready=%b want 1/22/1/1",
               s_out_valid, s_out_data, s_occupancy, s_in_ready);
    end
    tick();
    total++;
    if (s_out_valid !== 1'b0 || s_occupancy !== 2'd0 || s_stall_cnt !== 4'd5) begin
      bad++;
      $display("FAIL bp_drained: valid=%b occ=%0d stall=%0d want 0/0/5", s_out_valid, s_occupancy, s_stall_cnt);
    end
  endtask

  task automatic test_flush;
    s_out_ready = 1'b0;
    s_stat_clr  = 1'b1;
    drive_s(1'b1, 32'h55);
    tick();
    s_stat_clr = 1'b0;
    drive_s(1'b1, 32'h33);
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    total++;
    if (s_out_valid !== 1'b0 || s_out_ctrl !== 8'h00 || s_occupancy !== 2'd0 || s_in_ready !== 1'b1 ||
        s_out_data !== 32'h55 || s_stall_cnt !== 4'd1) begin
      bad++;
      $display("FAIL flush_one: valid=%b ctrl=%h occ=%0d in_ready=%b data=%h stall=%0d want 0/00/0/1/55/1",
               s_out_valid, s_out_ctrl, s_occupancy, s_in_ready, s_out_data, s_stall_cnt);
    end
    drive_s(1'b1, 32'h66);
    tick();
    drive_s(1'b1, 32'h77);
    tick();
    drive_s(1'b1, 32'h33);
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    total++;
    if (s_out_valid !== 1'b0 || s_out_ctrl !== 8'h00 || s_occupancy !== 2'd0 || s_in_ready !== 1'b1 ||
        s_out_data !== 32'h66 || s_stall_cnt !== 4'd3) begin
      bad++;
      $display("FAIL flush_two: valid=%b ctrl=%h occ=%0d in_ready=%b data=%h stall=%0d want 0/00/0/1/66/3",
               s_out_valid, s_out_ctrl, s_occupancy, s_in_ready, s_out_data, s_stall_cnt);
    end
    drive_s(1'b0, 32'h0);
    s_out_ready = 1'b1;
    tick();
    total++;
    if (s_out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_leak: valid=%b want 0", s_out_valid); end
  endtask

  task automatic test_single;
    n_out_ready = 1'b0;
    drive_n(1'b1, 32'h40);
    tick();
    total++;
    if (n_out_valid !== 1'b1 || n_in_ready !== 1'b0 || n_occupancy !== 2'd1) begin
      bad++;
      $display("FAIL single_blocked: valid=%b in_ready=%b occ=%0d want 1/0/1", n_out_valid, n_in_ready, n_occupancy);
    end
    drive_n(1'b0, 32'h0);
    n_out_ready = 1'b1;
    #1;
    total++;
    if (n_in_ready !== 1'b1) begin bad++; $display("FAIL single_comb_ready: in_ready=%b want 1", n_in_ready); end
    drive_n(1'b1, 32'h44);
    tick();
    total++;
    if (n_out_valid !== 1'b1 || n_out_data !== 32'h44 || n_occupancy !== 2'd1) begin
      bad++;
      $display("FAIL single_b2b: valid=%b data=%h occ=%0d want 1/44/1", n_out_valid, n_out_data, n_occupancy);
    end
    drive_n(1'b0, 32'h0);
    tick();
    total++;
    if (n_out_valid !== 1'b0 || n_out_ctrl !== 8'h00 || n_out_data !== 32'h44 || n_stall_cnt !== 16'd0) begin
      bad++;
      $display("FAIL single_empty: valid=%b ctrl=%h data=%h stall=%0d want 0/00/44/0",
               n_out_valid, n_out_ctrl, n_out_data, n_stall_cnt);
    end
  endtask

  task automatic test_saturate;
    s_out_ready = 1'b0;
    s_stat_clr  = 1'b1;
    drive_s(1'b1, 32'hAB);
    tick();
    s_stat_clr = 1'b0;
    drive_s(1'b0, 32'h0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) begin
        total++;
        if (s_stall_cnt !== 4'd14) begin bad++; $display("FAIL sat_ramp: stall=%0d want 14", s_stall_cnt); end
      end
    end
    total++;
    if (s_stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold: stall=%0d want 15", s_stall_cnt); end
    s_stat_clr = 1'b1;
    tick();
    total++;
    if (s_stall_cnt !== 4'd0) begin bad++; $display("FAIL sat_clear: stall=%0d want 0", s_stall_cnt); end
    s_stat_clr = 1'b0;
    tick();
    total++;
    if (s_stall_cnt !== 4'd1) begin bad++; $display("FAIL sat_resume: stall=%0d want 1", s_stall_cnt); end
    s_out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      drive_s(1'($urandom_range(0, 1)), $urandom);
      drive_n(1'($urandom_range(0, 1)), $urandom);
      s_out_ready = ($urandom_range(0, 3) != 0);
      n_out_ready = ($urandom_range(0, 2) != 0);
      tick();
      total++;
      if (s_occupancy !== 2'(sq.size()) || s_out_valid !== (sq.size() != 0)) begin
        bad++;
        $display("FAIL rand_skid_occ: occ=%0d valid=%b want occ=%0d", s_occupancy, s_out_valid, sq.size());
      end
      total++;
      if (n_occupancy !== 2'(nq.size()) || n_out_valid !== (nq.size() != 0)) begin
        bad++;
        $display("FAIL rand_single_occ: occ=%0d valid=%b want occ=%0d", n_occupancy, n_out_valid, nq.size());
      end
    end
    drive_s(1'b0, 32'h0);
    drive_n(1'b0, 32'h0);
    s_out_ready = 1'b1;
    n_out_ready = 1'b1;
    repeat (4) tick();
    total++;
    if (sq.size() != 0 || nq.size() != 0 || s_out_valid !== 1'b0 || n_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rand_drain: pending skid=%0d single=%0d valid=%b/%b want 0/0/0/0",
               sq.size(), nq.size(), s_out_valid, n_out_valid);
    end
  endtask

  task automatic test_async_reset;
    s_out_ready = 1'b0;
    drive_s(1'b1, 32'h3F);
    tick();
    drive_s(1'b1, 32'h7F);
    tick();
    drive_s(1'b0, 32'h0);
    total++;
    if (s_occupancy !== 2'd2 || s_out_ctrl !== 8'hFF) begin
      bad++;
      $display("FAIL areset_setup: occ=%0d ctrl=%h want 2/ff", s_occupancy, s_out_ctrl);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({s_out_valid, s_out_ctrl, s_out_data, s_out_pc, s_occupancy} !== 75'd0 || s_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL areset_now: valid=%b ctrl=%h data=%h pc=%h occ=%0d in_ready=%b want zeros, in_ready 1",
               s_out_valid, s_out_ctrl, s_out_data, s_out_pc, s_occupancy, s_in_ready);
    end
    tick();
    #2 rst_n = 1'b1;
    s_out_ready = 1'b1;
    drive_s(1'b1, 32'h12);
    tick();
    total++;
    if (s_out_valid !== 1'b1 || s_out_data !== 32'h12 || s_out_pc !== pc_of(32'h12)) begin
      bad++;
      $display("FAIL areset_resume: valid=%b data=%h pc=%h want 1/12/%h", s_out_valid, s_out_data, s_out_pc, pc_of(32'h12));
    end
    drive_s(1'b0, 32'h0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    s_out_ready = 1'b0; s_flush = 1'b0; s_stat_clr = 1'b0;
    n_out_ready = 1'b0; n_flush = 1'b0; n_stat_clr = 1'b0;
    drive_s(1'b0, 32'h0);
    drive_n(1'b0, 32'h0);
    #22 rst_n = 1'b1;
    #1;
    test_reset();
    tick();
    test_stream();
    test_backpressure();
    test_flush();
    test_single();
    test_saturate();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
